// File: rtl/z80_bus_ctrl.sv
// Bus controller for the fz80 core: decodes CPU cycles into ROM/RAM/IO selects with
// per-region wait states, and lends the bus to one DMA master. Optional macro: BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module z80_bus_ctrl #(
   parameter logic [15:0] ROM_TOP       = 16'h3FFF,
   parameter int          ROM_WAIT      = 1,
   parameter int          RAM_WAIT      = 0,
   parameter int          IO_WAIT       = 2,
   parameter int          DMA_MAX_BURST = 16
) (
   input  logic        i_clk,
   input  logic        i_n_rst,
   input  logic        i_cpu_mreq,
   input  logic        i_cpu_iorq,
   input  logic        i_cpu_rd,
   input  logic        i_cpu_wr,
   input  logic [15:0] i_cpu_addr,
   input  logic        i_cpu_busack,
   output logic        o_cpu_busreq,
   output logic        o_cpu_waitreq,
   input  logic        i_dma_req,
   input  logic [15:0] i_dma_addr,
   input  logic        i_dma_we,
   input  logic        i_dma_beat,
   output logic        o_dma_gnt,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_we,
   output logic        o_rom_cs,
   output logic        o_ram_cs,
   output logic        o_io_cs,
   output logic        o_err_rom_wr,
`ifdef BUS_TIMEOUT_EN
   output logic        o_busreq_timeout,
`endif
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACCESS  = 3'd1,
      S_BUSREQ  = 3'd2,
      S_DMA_OWN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_mem_act;
   logic        r_io_act;
   logic        r_req_d;
   logic        r_busack;
   logic        r_is_io;
   logic [7:0]  r_wait;
   logic [7:0]  r_beat;
   logic        r_block;
   logic        r_err;
`ifdef BUS_TIMEOUT_EN
   logic [7:0]  r_to;
`endif

   logic        w_mem_act;
   logic        w_io_act;
   logic        w_req;
   logic        w_start;
   logic        w_cpu_rom;
   logic        w_dma_rom;
   logic [7:0]  w_wait_load;
   logic [7:0]  w_beat_next;
   logic        w_set_err;
   logic        w_set_block;
   logic        w_clr_block;

   assign w_mem_act   = i_cpu_mreq & (i_cpu_rd | i_cpu_wr);
   assign w_io_act    = i_cpu_iorq & (i_cpu_rd | i_cpu_wr);
   assign w_req       = r_mem_act | r_io_act;
   assign w_start     = w_req & ~r_req_d;
   assign w_cpu_rom   = (i_cpu_addr <= ROM_TOP);
   assign w_dma_rom   = (i_dma_addr <= ROM_TOP);
   assign w_wait_load = r_io_act ? 8'(IO_WAIT) : (w_cpu_rom ? 8'(ROM_WAIT) : 8'(RAM_WAIT));
   assign w_beat_next = r_beat + {7'd0, i_dma_beat};

   assign o_err_rom_wr = r_err;
   assign o_dbg_state  = r_state;

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state   <= S_IDLE;
         r_mem_act <= 1'b0;
         r_io_act  <= 1'b0;
         r_req_d   <= 1'b0;
         r_busack  <= 1'b0;
         r_is_io   <= 1'b0;
         r_wait    <= 8'd0;
         r_beat    <= 8'd0;
         r_block   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_mem_act <= w_mem_act;
         r_io_act  <= w_io_act;
         r_req_d   <= w_req;
         r_busack  <= i_cpu_busack;
         if (r_state == S_IDLE && w_start) begin
            r_is_io <= r_io_act;
            r_wait  <= (w_wait_load == 8'd0) ? 8'd0 : w_wait_load - 8'd1;
         end else if (r_state == S_ACCESS && r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
         end
         // Beats only count while the DMA master owns the bus.
         r_beat <= (r_state == S_DMA_OWN) ? w_beat_next : 8'd0;
         if (w_set_block)
            r_block <= 1'b1;
         else if (w_clr_block)
            r_block <= 1'b0;
         if (w_set_err)
            r_err <= 1'b1;
      end
   end

`ifdef BUS_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst)
         r_to <= 8'd0;
      else
         r_to <= (r_state == S_BUSREQ) ? r_to + 8'd1 : 8'd0;
   end
`endif

   always_comb begin
      w_next        = r_state;
      o_cpu_busreq  = 1'b0;
      o_cpu_waitreq = 1'b0;
      o_dma_gnt     = 1'b0;
      o_mem_addr    = 16'd0;
      o_mem_we      = 1'b0;
      o_rom_cs      = 1'b0;
      o_ram_cs      = 1'b0;
      o_io_cs       = 1'b0;
      w_set_err     = 1'b0;
      w_set_block   = 1'b0;
      w_clr_block   = 1'b0;
`ifdef BUS_TIMEOUT_EN
      o_busreq_timeout = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next        = S_ACCESS;
               o_cpu_waitreq = (w_wait_load != 8'd0);
            end else if (i_dma_req && !r_block) begin
               w_next = S_BUSREQ;
            end
         end
         S_ACCESS: begin
            if (!w_req) begin
               w_next      = S_IDLE;
               w_clr_block = ~r_is_io;
            end else begin
               o_cpu_waitreq = (r_wait != 8'd0);
               o_mem_addr    = i_cpu_addr;
               if (r_is_io) begin
                  o_io_cs  = 1'b1;
                  o_mem_we = i_cpu_wr;
               end else if (w_cpu_rom) begin
                  // A write into ROM is refused: no select, no strobe, sticky error.
                  o_rom_cs  = i_cpu_rd & ~i_cpu_wr;
                  w_set_err = i_cpu_wr;
               end else begin
                  o_ram_cs = 1'b1;
                  o_mem_we = i_cpu_wr;
               end
            end
         end
         S_BUSREQ: begin
            o_cpu_busreq = 1'b1;
            if (r_busack) begin
               w_next = S_DMA_OWN;
`ifdef BUS_TIMEOUT_EN
            end else if (r_to == 8'hFF) begin
               w_next           = S_IDLE;
               o_cpu_busreq     = 1'b0;
               w_set_block      = 1'b1;
               o_busreq_timeout = 1'b1;
`endif
            end
         end
         S_DMA_OWN: begin
            o_cpu_busreq = 1'b1;
            o_dma_gnt    = 1'b1;
            o_mem_addr   = i_dma_addr;
            if (w_dma_rom) begin
               o_rom_cs  = ~i_dma_we;
               w_set_err = i_dma_we;
            end else begin
               o_ram_cs = 1'b1;
               o_mem_we = i_dma_we;
            end
            // The burst limit forces the CPU to finish one memory access before the next grant.
            if (w_beat_next == 8'(DMA_MAX_BURST)) begin
               w_next      = S_RELEASE;
               w_set_block = 1'b1;
            end else if (!i_dma_req) begin
               w_next = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!r_busack)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
